// File: rtl/miner_nonce_scheduler.sv
// Multi-round nonce-search controller: dispatches NUM_CORES nonces per round, picks the lowest hit.
// Optional per-round WAIT watchdog enabled by defining MINER_WATCHDOG_EN.
module miner_nonce_scheduler #(
    parameter int unsigned NUM_CORES      = 3,
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned HASH_W         = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NONCE_W-1:0]          nonce_base,
    input  logic [NONCE_W-1:0]          nonce_limit,
    output logic [NUM_CORES-1:0]        core_enable,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]        core_finished,
    input  logic [NUM_CORES-1:0]        core_correct,
    input  logic [NUM_CORES*HASH_W-1:0] core_hash,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic                        exhausted,
    output logic                        timeout,
    output logic [HASH_W-1:0]           correct_hash,
    output logic [NONCE_W-1:0]          correct_nonce,
    output logic [NONCE_W-1:0]          rounds
);
    localparam int unsigned WW = NONCE_W + 1;

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StEval, StDone} state_t;

    state_t                       state;
    logic [NONCE_W-1:0]           cur_base;
    logic [NONCE_W-1:0]           limit;
    logic [NUM_CORES-1:0]         mask;

    logic [NONCE_W-1:0]           launch_base;
    logic [NONCE_W-1:0]           launch_limit;
    logic [NUM_CORES-1:0]         launch_mask;
    logic [NUM_CORES*NONCE_W-1:0] launch_nonce;
    logic [NUM_CORES-1:0]         hits;
    logic                         hit_any;
    logic [NONCE_W-1:0]           hit_nonce;
    logic [HASH_W-1:0]            hit_hash;
    logic                         last_round;

`ifdef MINER_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    // Range checks use one extra bit so a limit at the top of the nonce space never wraps.
    always_comb begin
        launch_base  = (state == StEval) ? cur_base + NONCE_W'(NUM_CORES) : nonce_base;
        launch_limit = (state == StEval) ? limit : nonce_limit;
        launch_mask  = '0;
        launch_nonce = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            launch_mask[i] = (WW'(launch_base) + WW'(i)) <= WW'(launch_limit);
            launch_nonce[i*NONCE_W +: NONCE_W] = launch_base + NONCE_W'(i);
        end
        hits      = core_correct & mask;
        hit_any   = |hits;
        hit_nonce = '0;
        hit_hash  = '1;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_nonce = cur_base + NONCE_W'(i);
                hit_hash  = core_hash[i*HASH_W +: HASH_W];
            end
        end
        last_round = (WW'(cur_base) + WW'(NUM_CORES)) > WW'(limit);
    end

    assign core_enable = (state == StLaunch && !abort) ? mask : '0;
    assign busy        = (state == StLaunch) || (state == StWait) || (state == StEval);
    assign done        = (state == StDone);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= StIdle;
            cur_base      <= '0;
            limit         <= '0;
            mask          <= '0;
            core_nonce    <= '0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            timeout       <= 1'b0;
            correct_hash  <= '1;
            correct_nonce <= '0;
            rounds        <= '0;
`ifdef MINER_WATCHDOG_EN
            wd_cnt        <= '0;
`endif
        end else if (abort) begin
            state     <= StIdle;
            found     <= 1'b0;
            exhausted <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        cur_base      <= nonce_base;
                        limit         <= nonce_limit;
                        rounds        <= '0;
                        found         <= 1'b0;
                        timeout       <= 1'b0;
                        correct_hash  <= '1;
                        correct_nonce <= '0;
                        if (nonce_base > nonce_limit) begin
                            exhausted <= 1'b1;
                            state     <= StDone;
                        end else begin
                            exhausted  <= 1'b0;
                            mask       <= launch_mask;
                            core_nonce <= launch_nonce;
                            state      <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
`ifdef MINER_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= StWait;
                end
                StWait: begin
                    if ((core_finished & mask) == mask) begin
                        state <= StEval;
`ifdef MINER_WATCHDOG_EN
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout       <= 1'b1;
                        found         <= 1'b0;
                        exhausted     <= 1'b0;
                        correct_hash  <= '1;
                        correct_nonce <= '0;
                        state         <= StDone;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                StEval: begin
                    rounds <= rounds + 1'b1;
                    if (hit_any) begin
                        correct_hash  <= hit_hash;
                        correct_nonce <= hit_nonce;
                        found         <= 1'b1;
                        state         <= StDone;
                    end else if (last_round) begin
                        exhausted <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cur_base   <= launch_base;
                        mask       <= launch_mask;
                        core_nonce <= launch_nonce;
                        state      <= StLaunch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Scoreboard bench for miner_nonce_scheduler: directed searches against a behavioural core bank.
module tb_miner_nonce_scheduler;
    localparam int N  = 3;
    localparam int NW = 32;
    localparam int HW = 256;

    typedef struct packed {
        logic          f;
        logic          e;
        logic          t;
        logic [HW-1:0] h;
        logic [NW-1:0] n;
        logic [NW-1:0] r;
    } res_t;

    typedef struct packed {
        logic [N-1:0]    en;
        logic [N*NW-1:0] nonces;
    } lau_t;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            start;
    logic            abort;
    logic [NW-1:0]   nonce_base;
    logic [NW-1:0]   nonce_limit;
    logic [N-1:0]    core_enable;
    logic [N*NW-1:0] core_nonce;
    logic [N-1:0]    core_finished;
    logic [N-1:0]    core_correct;
    logic [N*HW-1:0] core_hash;
    logic            busy;
    logic            done;
    logic            found;
    logic            exhausted;
    logic            timeout;
    logic [HW-1:0]   correct_hash;
    logic [NW-1:0]   correct_nonce;
    logic [NW-1:0]   rounds;

    int   n_vec = 0;
    int   n_err = 0;
    res_t res_q[$];
    lau_t lau_q[$];

    logic [N-1:0] hit_pat [4];
    int           launch_cnt = 0;
    int           core_delay = 2;
    logic         stall = 1'b0;
    logic         done_prev = 1'b0;

    miner_nonce_scheduler #(
        .NUM_CORES     (N),
        .NONCE_W       (NW),
        .HASH_W        (HW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .nonce_base   (nonce_base),
        .nonce_limit  (nonce_limit),
        .core_enable  (core_enable),
        .core_nonce   (core_nonce),
        .core_finished(core_finished),
        .core_correct (core_correct),
        .core_hash    (core_hash),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .exhausted    (exhausted),
        .timeout      (timeout),
        .correct_hash (correct_hash),
        .correct_nonce(correct_nonce),
        .rounds       (rounds)
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] hash_of(input logic [NW-1:0] n);
        return {~n, 192'h0, n};
    endfunction

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_launch(input logic [N-1:0] en, input logic [NW-1:0] n0,
                               input logic [NW-1:0] n1, input logic [NW-1:0] n2);
        lau_t l;
        l.en     = en;
        l.nonces = {n2, n1, n0};
        lau_q.push_back(l);
    endtask

    task automatic push_res(input logic f, input logic e, input logic t, input logic [HW-1:0] h,
                            input logic [NW-1:0] n, input logic [NW-1:0] r);
        res_t x;
        x.f = f; x.e = e; x.t = t; x.h = h; x.n = n; x.r = r;
        res_q.push_back(x);
    endtask

    task automatic set_pats(input logic [N-1:0] p0, input logic [N-1:0] p1);
        hit_pat[0] = p0;
        hit_pat[1] = p1;
        hit_pat[2] = '0;
        hit_pat[3] = '0;
    endtask

    task automatic do_start(input logic [NW-1:0] b, input logic [NW-1:0] l);
        @(negedge clk);
        launch_cnt  = 0;
        nonce_base  = b;
        nonce_limit = l;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: done still 0 after %0d cycles, expected 1", name, k);
        end
        @(negedge clk);
    endtask

    // Behavioural core bank: answers each launch after core_delay cycles.
    initial begin
        logic [N-1:0] en;
        logic [N-1:0] pat;
        core_finished = '0;
        core_correct  = '0;
        core_hash     = '0;
        forever begin
            @(negedge clk);
            if (|core_enable) begin
                en  = core_enable;
                pat = (launch_cnt < 4) ? hit_pat[launch_cnt] : '0;
                launch_cnt++;
                core_finished = '0;
                core_correct  = '0;
                repeat (core_delay) @(negedge clk);
                if (!stall) begin
                    for (int i = 0; i < N; i++) begin
                        if (en[i]) begin
                            core_finished[i]        = 1'b1;
                            core_correct[i]         = pat[i];
                            core_hash[i*HW +: HW]   = hash_of(core_nonce[i*NW +: NW]);
                        end
                    end
                end
            end
        end
    end

    // Monitor: checks every launch and every rising done against the scoreboard queues.
    initial begin
        lau_t l;
        res_t x;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (|core_enable) begin
                    if (lau_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL launch: unexpected core_enable=%b, none expected", core_enable);
                    end else begin
                        l = lau_q.pop_front();
                        check("core_enable", {253'h0, core_enable}, {253'h0, l.en});
                        check("core_nonce", {160'h0, core_nonce}, {160'h0, l.nonces});
                    end
                end
                if (done && !done_prev) begin
                    if (res_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL result: unexpected done, none expected");
                    end else begin
                        x = res_q.pop_front();
                        check("found", {255'h0, found}, {255'h0, x.f});
                        check("exhausted", {255'h0, exhausted}, {255'h0, x.e});
                        check("timeout", {255'h0, timeout}, {255'h0, x.t});
                        check("correct_hash", correct_hash, x.h);
                        check("correct_nonce", {224'h0, correct_nonce}, {224'h0, x.n});
                        check("rounds", {224'h0, rounds}, {224'h0, x.r});
                    end
                end
            end
            done_prev = done;
        end
    end

    initial begin
        logic [HW-1:0] ones;
        int k;
        ones        = '1;
        n_rst       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_base  = '0;
        nonce_limit = '0;
        set_pats('0, '0);
        repeat (3) @(negedge clk);
        check("rst_busy", {255'h0, busy}, 0);
        check("rst_done", {255'h0, done}, 0);
        check("rst_found", {255'h0, found}, 0);
        check("rst_exhausted", {255'h0, exhausted}, 0);
        check("rst_timeout", {255'h0, timeout}, 0);
        check("rst_hash", correct_hash, ones);
        check("rst_nonce", {224'h0, correct_nonce}, 0);
        check("rst_rounds", {224'h0, rounds}, 0);
        check("rst_core_nonce", {160'h0, core_nonce}, 0);
        check("rst_core_enable", {253'h0, core_enable}, 0);
        n_rst = 1'b1;

        // base > limit: straight to DONE with no launch
        push_res(1'b0, 1'b1, 1'b0, ones, 32'h0, 32'd0);
        do_start(32'h100, 32'h50);
        wait_done("empty_range");

        // lane 1 hits in round 1
        core_delay = 1;
        set_pats(3'b010, '0);
        push_launch(3'b111, 32'h10, 32'h11, 32'h12);
        push_res(1'b1, 1'b0, 1'b0, hash_of(32'h11), 32'h11, 32'd1);
        do_start(32'h10, 32'h20);
        wait_done("lane1_hit");

        // lanes 0 and 2 hit in round 2: lowest lane wins
        core_delay = 3;
        set_pats('0, 3'b101);
        push_launch(3'b111, 32'd0, 32'd1, 32'd2);
        push_launch(3'b111, 32'd3, 32'd4, 32'd5);
        push_res(1'b1, 1'b0, 1'b0, hash_of(32'd3), 32'd3, 32'd2);
        do_start(32'd0, 32'd7);
        wait_done("lowest_lane");

        // no hit, partial last round
        set_pats('0, '0);
        push_launch(3'b111, 32'd0, 32'd1, 32'd2);
        push_launch(3'b011, 32'd3, 32'd4, 32'd5);
        push_res(1'b0, 1'b1, 1'b0, ones, 32'd0, 32'd2);
        do_start(32'd0, 32'd4);
        wait_done("exhaust");

        // top of nonce space must not wrap
        push_launch(3'b011, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0);
        push_res(1'b0, 1'b1, 1'b0, ones, 32'd0, 32'd1);
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_done("no_wrap");
        repeat (6) @(negedge clk);
        check("no_wrap_hold_done", {255'h0, done}, 1);

        // abort in WAIT of round 2, then restart
        push_launch(3'b111, 32'h40, 32'h41, 32'h42);
        push_launch(3'b111, 32'h43, 32'h44, 32'h45);
        do_start(32'h40, 32'h60);
        k = 0;
        while (launch_cnt < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_round2", launch_cnt, 2);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {255'h0, busy}, 0);
        check("abort_done", {255'h0, done}, 0);
        check("abort_found", {255'h0, found}, 0);
        check("abort_rounds_hold", {224'h0, rounds}, 1);
        repeat (6) @(negedge clk);
        set_pats(3'b100, '0);
        push_launch(3'b111, 32'h200, 32'h201, 32'h202);
        push_res(1'b1, 1'b0, 1'b0, hash_of(32'h202), 32'h202, 32'd1);
        do_start(32'h200, 32'h2FF);
        check("restart_rounds", {224'h0, rounds}, 0);
        check("restart_busy", {255'h0, busy}, 1);
        wait_done("restart");

`ifdef MINER_WATCHDOG_EN
        // cores never finish: watchdog ends the round after 8 WAIT cycles
        stall = 1'b1;
        push_launch(3'b111, 32'd0, 32'd1, 32'd2);
        push_res(1'b0, 1'b0, 1'b1, ones, 32'd0, 32'd0);
        do_start(32'd0, 32'd10);
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wd_latency", k, 10);
        @(negedge clk);
        stall = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("launch_queue_empty", lau_q.size(), 0);
        check("result_queue_empty", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/miner_nonce_scheduler.md
Name: miner_nonce_scheduler

Overview:
- Multi-round nonce-search controller for a parametrised bank of NUM_CORES miner cores.
- Each round, it dispatches nonces cur_base+0 through cur_base+NUM_CORES-1, waits for every enabled core to finish, then picks the lowest-index correct lane.
- It sweeps from nonce_base up to nonce_limit inclusive, advancing NUM_CORES per round, until a hit, exhaustion or abort.
- Sits between the top-level miner control and the instantiated core array; results are registered and held.

Parameters:
NUM_CORES, 3, number of core lanes (>=1)
NONCE_W, 32, nonce width
HASH_W, 256, hash width
TIMEOUT_CYCLES, 1024, max WAIT cycles per round (used only with MINER_WATCHDOG_EN)

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
start  in  1  begin a search; sampled only in IDLE or DONE
abort  in  1  cancel the search, return to IDLE
nonce_base  in  NONCE_W  first nonce; sampled on accepted start
nonce_limit  in  NONCE_W  last nonce, inclusive; sampled on accepted start
core_enable  out  NUM_CORES  per-lane one-cycle launch pulse
core_nonce  out  NUM_CORES*NONCE_W  lane i nonce at bits [i*NONCE_W +: NONCE_W]
core_finished  in  NUM_CORES  per-lane finished level
core_correct  in  NUM_CORES  per-lane hash<=target flag, valid while finished
core_hash  in  NUM_CORES*HASH_W  per-lane hash, same packing as core_nonce
busy  out  1  high in LAUNCH/WAIT/EVAL
done  out  1  high in DONE
found  out  1  result valid hit
exhausted  out  1  range searched with no hit
timeout  out  1  watchdog fired
correct_hash  out  HASH_W  winning hash; all-ones if none
correct_nonce  out  NONCE_W  winning nonce; 0 if none
rounds  out  NONCE_W  completed rounds in the current search

Behaviour:
- Reset (n_rst=0 at posedge):
  - state=IDLE; all outputs 0 except correct_hash=all-ones.
  - core_nonce=0; internal cur_base and limit registers = 0.
- States: IDLE, LAUNCH, WAIT, EVAL, DONE.
- IDLE/DONE + start:
  - cur_base<=nonce_base, limit<=nonce_limit, rounds<=0.
  - found/exhausted/timeout cleared; correct_hash<=all-ones, correct_nonce<=0 → LAUNCH.
- Start with nonce_base>nonce_limit: go directly to DONE with exhausted=1 and no launch.
- LAUNCH (1 cycle):
  - Lane i is in range iff cur_base+i <= limit, computed in NONCE_W+1 bits with no wrap.
  - core_nonce lane i <= cur_base+i (truncated).
  - core_enable[i]=1 for in-range lanes only; latch in-range mask → WAIT.
- core_nonce is held stable from LAUNCH until the next LAUNCH.
- WAIT: stay until (core_finished & mask)==mask → EVAL. Out-of-range lanes are ignored.
- EVAL (1 cycle): hits = core_correct & mask.
  - Any hit: lowest index i wins → correct_hash<=lane i hash, correct_nonce<=cur_base+i, found<=1 → DONE.
  - Else if cur_base+NUM_CORES > limit (NONCE_W+1-bit compare): exhausted<=1 → DONE.
  - Else: cur_base<=cur_base+NUM_CORES → LAUNCH.
  - rounds increments on every EVAL exit.
- DONE: outputs held until the next start or abort. start in LAUNCH/WAIT/EVAL is ignored.
- abort, any state:
  - Next state IDLE; core_enable is forced 0 that cycle.
  - found/exhausted/timeout<=0; correct_hash/correct_nonce/rounds hold their last values.
- Priority: n_rst > abort > start > normal progress.
- nonce_limit = 2^NONCE_W-1 must terminate: the wide compare prevents cur_base wrap.
- Latency: accepted start → first core_enable is 1 cycle. All finished seen in WAIT → done high is 2 cycles (EVAL, then DONE) on a hit.

Optional Feature:
- Macro MINER_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on LAUNCH and counts in WAIT.
  - When it reaches TIMEOUT_CYCLES with lanes still unfinished: timeout<=1, found=0, exhausted=0, correct_hash=all-ones → DONE.
  - rounds is not incremented for the timed-out round.
- Undefined: no counter; WAIT is unbounded; timeout is tied 0.

Test Plan:
- NUM_CORES=3, base=0x10, limit=0x20, lane 1 correct in round 1 → core_nonce 0x10/0x11/0x12; found=1, correct_nonce=0x11, rounds=1.
- base=0, limit=7, lanes 0 and 2 both correct in round 2 → correct_nonce=3 (lowest lane wins), rounds=2.
- base=0, limit=4, never correct → round 2 core_enable=3'b011 with lane 2 finished held 0; exhausted=1, rounds=2, correct_hash all-ones, correct_nonce=0.
- base=0xFFFFFFFE, limit=0xFFFFFFFF → single round with mask 3'b011; exhausted=1; no wrap back to 0.
- abort asserted in WAIT of round 2 → IDLE next cycle, busy=0, done=0. start reissued → rounds=0, nonces restart at the new base.
- MINER_WATCHDOG_EN, TIMEOUT_CYCLES=8, core_finished held 0 → timeout=1 and done=1 after 8 WAIT cycles; found=0.
